// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for regfile_mp
// Holds the default geometry, the "no zero register" marker and the depth helper.
package regfile_pkg;
    localparam int RF_WIDTH     = 64;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_NUM_RD    = 2;
    localparam int RF_ZERO_NONE = -1;

    function automatic int rf_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

    localparam int RF_DEPTH = rf_depth(RF_ADDR_W);
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of regfile_mp (mux, zero-register check, bypass)
// Ports: rd_addr in; wr_en/wr_addr/wr_data and rsv_en/rsv_addr are the same-cycle
//        write and reserve used for bypass; regs/busy are the stored state;
//        rd_data/rd_busy out.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [WIDTH-1:0]         regs [rf_depth(ADDR_W)],
    input  logic [rf_depth(ADDR_W)-1:0] busy,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_busy
);
    logic is_zero, hit;

    always_comb begin
        // A negative ZERO_REG never equals a zero-extended address, which disables the check.
        is_zero = int'(rd_addr) == ZERO_REG;
        hit     = BYPASS != 0 && wr_en && wr_addr == rd_addr;
        rd_data = is_zero ? '0 : hit ? wr_data : regs[rd_addr];
        // A same-cycle reserve of the bypassed register is a newer in-flight op, so it stays busy.
        rd_busy = is_zero ? 1'b0 : hit ? (rsv_en && rsv_addr == rd_addr) : busy[rd_addr];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with zero register, bypass and busy scoreboard
// Ports: clk; reset (async, active-low, clears all state); write/wrAddr/wrData writeback;
//        reserve/rsvAddr mark a register busy; rdAddr/rdData/rdBusy are packed
//        combinational read ports, port i at [i*ADDR_W +: ADDR_W] / [i*WIDTH +: WIDTH] / [i].
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     reserve,
    input  logic [ADDR_W-1:0]        rsvAddr,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*WIDTH-1:0]  rdData,
    output logic [NUM_RD-1:0]        rdBusy
);
    localparam int DEPTH = rf_depth(ADDR_W);

    // Storage keeps the plain name regs so benches can probe regs[k] hierarchically.
    logic [WIDTH-1:0] regs   [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             byp_wr, byp_rsv;

    always_comb begin
        regs_d = regs;
        busy_d = busy_q;
        if (write && int'(wrAddr) != ZERO_REG) begin
            regs_d[wrAddr] = wrData;
            busy_d[wrAddr] = 1'b0;
        end
        // Applied after the write so reserve wins on a same-address collision.
        if (reserve && int'(rsvAddr) != ZERO_REG)
            busy_d[rsvAddr] = 1'b1;
        // While reset is low nothing lands, so nothing may be forwarded either.
        byp_wr  = write && reset;
        byp_rsv = reserve && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs   <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs   <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .WIDTH   (WIDTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .rd_addr (rdAddr[i*ADDR_W +: ADDR_W]),
            .wr_en   (byp_wr),
            .wr_addr (wrAddr),
            .wr_data (wrData),
            .rsv_en  (byp_rsv),
            .rsv_addr(rsvAddr),
            .regs    (regs),
            .busy    (busy_q),
            .rd_data (rdData[i*WIDTH +: WIDTH]),
            .rd_busy (rdBusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default, no-bypass and 3-port variants)
module tb_regfile_mp;
    import regfile_pkg::*;

    typedef struct {
        string       tag;
        int          d;
        int          p;
        logic [63:0] data;
        logic        busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, write, reserve;
    logic [4:0]   wr_addr, rsv_addr;
    logic [63:0]  wr_data;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data, nb_data;
    logic [1:0]   rd_busy, nb_busy;
    logic         write3;
    logic [3:0]   wa3;
    logic [31:0]  wd3;
    logic [11:0]  ra3;
    logic [95:0]  rd3;
    logic [2:0]   rb3;
    logic [63:0]  m0 [32];
    logic [63:0]  m1 [32];
    exp_t         sb [$];
    int           n_assert = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .reserve(reserve), .rsvAddr(rsv_addr), .rdAddr(rd_addr),
        .rdData(rd_data), .rdBusy(rd_busy)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(RF_ZERO_NONE)) dut_nb (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .reserve(reserve), .rsvAddr(rsv_addr), .rdAddr(rd_addr),
        .rdData(nb_data), .rdBusy(nb_busy)
    );

    regfile_mp #(.WIDTH(32), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(RF_ZERO_NONE)) dut3 (
        .clk(clk), .reset(reset), .write(write3), .wrAddr(wa3), .wrData(wd3),
        .reserve(1'b0), .rsvAddr(4'd0), .rdAddr(ra3),
        .rdData(rd3), .rdBusy(rb3)
    );

    function automatic logic [63:0] val(int k);
        return {32'(k), ~32'(k)};
    endfunction

    function automatic logic [64:0] obs(int d, int p);
        if (d == 0) return {rd_busy[p], rd_data[p*64 +: 64]};
        if (d == 1) return {nb_busy[p], nb_data[p*64 +: 64]};
        return {rb3[p], 32'd0, rd3[p*32 +: 32]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(int a0, int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic expect_rd(string tag, int d, int p, logic [63:0] data, logic busy);
        sb.push_back('{tag, d, p, data, busy});
    endtask

    task automatic cmp(string tag, logic [63:0] o, logic [63:0] x);
        n_assert++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    task automatic check_sb;
        exp_t e;
        logic [64:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.d, e.p);
            cmp($sformatf("%s.d%0d.p%0d.data", e.tag, e.d, e.p), o[63:0], e.data);
            cmp($sformatf("%s.d%0d.p%0d.busy", e.tag, e.d, e.p), {63'd0, o[64]}, {63'd0, e.busy});
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            m0[k] = '0;
            m1[k] = '0;
        end
        // Reset held low while write/reserve are attempted.
        reset = 1'b0; write = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEADBEEF;
        reserve = 1'b1; rsv_addr = 5'd3; set_rd(3, 3);
        write3 = 1'b1; wa3 = 4'd3; wd3 = 32'hFFFF_FFFF; ra3 = {4'd3, 4'd3, 4'd3};
        repeat (2) tick;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) expect_rd("rst_hold", d, p, 64'd0, 1'b0);
        for (int p = 0; p < 3; p++) expect_rd("rst_hold3", 2, p, 64'd0, 1'b0);
        check_sb();
        reset = 1'b1; write = 1'b0; reserve = 1'b0; write3 = 1'b0;
        tick;
        expect_rd("rst_rel", 0, 0, 64'd0, 1'b0);
        expect_rd("rst_rel", 1, 1, 64'd0, 1'b0);
        check_sb();

        // Sweep: write {k,~k} then read k and (k+1)%32.
        for (int k = 0; k < 32; k++) begin
            write = 1'b1; wr_addr = 5'(k); wr_data = val(k);
            tick;
            write = 1'b0;
            m0[k] = (k == 31) ? 64'd0 : val(k);
            m1[k] = val(k);
            set_rd(k, (k + 1) % 32);
            #1;
            expect_rd("sweep", 0, 0, m0[k], 1'b0);
            expect_rd("sweep", 0, 1, m0[(k + 1) % 32], 1'b0);
            expect_rd("sweep", 1, 0, m1[k], 1'b0);
            expect_rd("sweep", 1, 1, m1[(k + 1) % 32], 1'b0);
            check_sb();
        end
        cmp("probe_r10", dut.regs[10], val(10));
        cmp("probe_r31", dut.regs[31], 64'd0);

        // Bypass: same-cycle forwarding on port 1 only in the bypassing instance.
        set_rd(6, 5); write = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
        #1;
        expect_rd("byp_pre", 0, 1, 64'h1234, 1'b0);
        expect_rd("byp_pre", 0, 0, m0[6], 1'b0);
        expect_rd("byp_pre", 1, 1, m1[5], 1'b0);
        check_sb();
        tick;
        write = 1'b0; m0[5] = 64'h1234; m1[5] = 64'h1234;
        #1;
        expect_rd("byp_post", 0, 1, 64'h1234, 1'b0);
        expect_rd("byp_post", 1, 1, 64'h1234, 1'b0);
        check_sb();

        // Busy scoreboard on register 7.
        reserve = 1'b1; rsv_addr = 5'd7; set_rd(7, 7);
        #1;
        expect_rd("rsv_pre", 0, 0, m0[7], 1'b0);
        check_sb();
        tick;
        reserve = 1'b0;
        #1;
        expect_rd("rsv_post", 0, 0, m0[7], 1'b1);
        expect_rd("rsv_post", 1, 1, m1[7], 1'b1);
        check_sb();
        write = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
        #1;
        expect_rd("wclr_pre", 0, 0, 64'h55, 1'b0);
        expect_rd("wclr_pre", 1, 0, m1[7], 1'b1);
        check_sb();
        tick;
        write = 1'b0; m0[7] = 64'h55; m1[7] = 64'h55;
        #1;
        expect_rd("wclr_post", 0, 1, 64'h55, 1'b0);
        expect_rd("wclr_post", 1, 1, 64'h55, 1'b0);
        check_sb();
        write = 1'b1; wr_data = 64'h66; reserve = 1'b1; rsv_addr = 5'd7;
        #1;
        expect_rd("wrsv_pre", 0, 0, 64'h66, 1'b1);
        expect_rd("wrsv_pre", 1, 0, 64'h55, 1'b0);
        check_sb();
        tick;
        write = 1'b0; reserve = 1'b0;
        #1;
        expect_rd("wrsv_post", 0, 0, 64'h66, 1'b1);
        expect_rd("wrsv_post", 1, 1, 64'h66, 1'b1);
        check_sb();
        cmp("probe_r7", dut.regs[7], 64'h66);

        // Zero register: ignored in dut, ordinary in dut_nb.
        write = 1'b1; wr_addr = 5'd31; wr_data = 64'hFF; reserve = 1'b1; rsv_addr = 5'd31;
        set_rd(31, 30);
        #1;
        expect_rd("zero_pre", 0, 0, 64'd0, 1'b0);
        expect_rd("zero_pre", 1, 0, m1[31], 1'b0);
        check_sb();
        tick;
        write = 1'b0; reserve = 1'b0;
        #1;
        expect_rd("zero_post", 0, 0, 64'd0, 1'b0);
        expect_rd("zero_post", 0, 1, m0[30], 1'b0);
        expect_rd("zero_post", 1, 0, 64'hFF, 1'b1);
        check_sb();
        cmp("probe_zero31", dut.regs[31], 64'd0);
        cmp("probe_nb31", dut_nb.regs[31], 64'hFF);

        // Reset asserted mid-cycle discards the pending write/reserve and clears busy.
        write = 1'b1; wr_addr = 5'd9; wr_data = 64'h99; reserve = 1'b1; rsv_addr = 5'd9;
        set_rd(9, 7);
        #1;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) expect_rd("mid_rst", d, p, 64'd0, 1'b0);
        check_sb();
        tick;
        reset = 1'b1; write = 1'b0; reserve = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) expect_rd("mid_rel", d, p, 64'd0, 1'b0);
        check_sb();
        cmp("probe_r9", dut.regs[9], 64'd0);

        // Three-port 32-bit / 16-deep variant.
        write3 = 1'b1; wa3 = 4'd0; wd3 = 32'hA;
        tick;
        wa3 = 4'd8; wd3 = 32'hB;
        tick;
        wa3 = 4'd15; wd3 = 32'hC;
        tick;
        write3 = 1'b0; ra3 = {4'd15, 4'd8, 4'd0};
        #1;
        expect_rd("p3_a", 2, 0, 64'hA, 1'b0);
        expect_rd("p3_a", 2, 1, 64'hB, 1'b0);
        expect_rd("p3_a", 2, 2, 64'hC, 1'b0);
        check_sb();
        ra3 = {4'd8, 4'd0, 4'd15};
        #1;
        expect_rd("p3_b", 2, 0, 64'hC, 1'b0);
        expect_rd("p3_b", 2, 1, 64'hA, 1'b0);
        expect_rd("p3_b", 2, 2, 64'hB, 1'b0);
        check_sb();
        ra3 = {4'd8, 4'd8, 4'd8};
        #1;
        for (int p = 0; p < 3; p++) expect_rd("p3_same", 2, p, 64'hB, 1'b0);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file; successor to the fixed 32x64 two-read file in the CPU datapath. Generalises width, depth and read-port count, and adds three features: an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for tracking outstanding writebacks. It sits between decode (read/reserve) and writeback (write).

## Interface
Parameters:
- WIDTH, 64, data bits per register
- ADDR_W, 5, address bits; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 31, index hardwired to zero; -1 disables
- BYPASS, 1, 1 = write data forwarded to same-cycle reads

Ports:
- clk  in  1  rising-edge clock (the only clock)
- reset  in  1  asynchronous, active-low; clears all state
- write  in  1  write enable
- wrAddr  in  ADDR_W  write address
- wrData  in  WIDTH  write data
- reserve  in  1  mark rsvAddr busy (writeback outstanding)
- rsvAddr  in  ADDR_W  reservation address
- rdAddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdData  out  NUM_RD*WIDTH  packed read data; combinational
- rdBusy  out  NUM_RD  busy flag of each read port's register; combinational

## Operation
- Storage: 2**ADDR_W registers of WIDTH bits, plus a busy bit per register.
- Write: on clk rise with write=1, reg[wrAddr] <= wrData and busy[wrAddr] <= 0.
- Reserve: on clk rise with reserve=1, busy[rsvAddr] <= 1.
- Write and reserve to the same address in the same cycle: data is written and busy ends at 1. Reserve wins because it represents a newer in-flight op.
- Zero register (ZERO_REG >= 0): reads return 0 and rdBusy = 0; writes and reserves to that index are ignored.
- Read: rdData[i] = reg[rdAddr[i]]; rdBusy[i] = busy[rdAddr[i]].
- Bypass (BYPASS=1), applied per port when write=1 and wrAddr == rdAddr[i] and the address is not ZERO_REG:
  - rdData[i] = wrData.
  - rdBusy[i] = 0, unless reserve=1 and rsvAddr == rdAddr[i] in the same cycle, in which case rdBusy[i] = 1.
- BYPASS=0: reads show pre-edge contents; the new value is visible the cycle after the write.
- Multiple ports may read the same address; there are no port conflicts.

## Timing
- Write and reserve take effect at the clk rise; write latency is 1 cycle (0 with bypass).
- Read path is combinational from rdAddr, register state and (with bypass) the write inputs.
- reset low, asynchronously: all registers = 0, all busy = 0, so every rdData = 0 and every rdBusy = 0 immediately. Writes and reserves are blocked while reset is low.
- Reset asserted mid-operation discards any pending write in that cycle. Deassertion is sampled synchronously; the first write can land at the first clk rise after reset goes high.
- Address wrap-around is not possible because all addresses are exactly ADDR_W bits wide.

## Structure
- Shared package regfile_pkg holds:
  - defaults RF_WIDTH=64, RF_ADDR_W=5, RF_NUM_RD=2
  - constant RF_ZERO_NONE = -1
  - localparam helper for depth
- Sub-module rf_read_port (mux, zero-register check, bypass compare for one port) is instantiated NUM_RD times via generate.
- The storage and busy arrays live in the top module.
- Debug visibility: expose the storage array hierarchically (regs[k]) so the bench can probe any register.

## Test plan
- Reset: hold reset low, drive write=1 to address 3 with 0xDEADBEEF → all rdData = 0, all rdBusy = 0. Release reset, read address 3 → 0.
- Sweep: for k = 0..31 write {k, ~k}, then read ports 0/1 at k and (k+1)%32 → matching values; address 31 reads 0 (ZERO_REG=31).
- Bypass: write 0x1234 to address 5 while port 1 reads 5 → rdData[1] = 0x1234 in the same cycle. With BYPASS=0 the old value shows that cycle and 0x1234 appears the next.
- Scoreboard: reserve address 7 → rdBusy = 1 next cycle. Write address 7 = 0x55 → busy clears, data 0x55. Simultaneous write and reserve of 7 → busy stays 1, data is written.
- Zero register: reserve 31 and write 31 = 0xFF → rdData = 0, rdBusy = 0. Repeat with ZERO_REG=-1 → address 31 holds 0xFF.
- Parameters: WIDTH=32, ADDR_W=4, NUM_RD=3 → three independent ports read addresses 0/8/15 correctly after writes 0xA/0xB/0xC.
